// File: rtl/uart_rx_frame_if.sv
// Serial-in / byte-out bundle for one receive channel.
// The receiver is the master: it produces the byte stream and the status flags.
// DATA_BITS must match the DATA_BITS of the connected uart_rx_frame.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;

    modport master (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Parity_Err,
        output o_Frame_Err,
        output o_Break,
        output o_Busy
    );

    modport slave (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Parity_Err,
        input  o_Frame_Err,
        input  o_Break,
        input  o_Busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// 3-sample majority vote per bit, parity/framing error and line-break reporting.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    uart_rx_frame_if.master rx_if
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] M_LO    = CW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CW-1:0] M_MID   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] M_HI    = CW'((CLKS_PER_BIT - 1) / 2 + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [1:0]           sync_reg;
    logic                 rx_s;

    logic [2:0]           state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next, cnt_inc;
    logic [IW-1:0]        bit_idx_reg, bit_idx_next;
    logic                 stop_idx_reg, stop_idx_next;
    logic                 samp_lo_reg, samp_lo_next;
    logic                 samp_mid_reg, samp_mid_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 xor_reg, xor_next;
    logic                 zero_reg, zero_next;
    logic                 perr_acc_reg, perr_acc_next;
    logic                 ferr_acc_reg, ferr_acc_next;

    logic [DATA_BITS-1:0] byte_reg, byte_next;
    logic                 perr_reg, perr_next;
    logic                 ferr_reg, ferr_next;
    logic                 dv_reg, dv_next;
    logic                 brk_reg, brk_next;

    logic                 maj;
    logic                 par_calc;
    logic                 ferr_now;
    logic                 last_stop;

    assign rx_s = sync_reg[1];

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_if.i_Rx_Serial};
        end
    end

    // The third vote is the live sample at M+1, so the decision needs no extra cycle.
    assign maj       = (samp_lo_reg & samp_mid_reg) | (samp_lo_reg & rx_s) | (samp_mid_reg & rx_s);
    assign par_calc  = xor_reg ^ maj;
    assign ferr_now  = ferr_acc_reg | ~maj;
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_reg;
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CW'(1);

    // Frame sequencing: bit timing, majority decisions and result/pulse generation.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        samp_lo_next  = samp_lo_reg;
        samp_mid_next = samp_mid_reg;
        shift_next    = shift_reg;
        xor_next      = xor_reg;
        zero_next     = zero_reg;
        perr_acc_next = perr_acc_reg;
        ferr_acc_next = ferr_acc_reg;
        byte_next     = byte_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        dv_next       = 1'b0;
        brk_next      = 1'b0;

        if (state_reg != S_IDLE) begin
            cnt_next = cnt_inc;
            if (cnt_reg == M_LO) begin
                samp_lo_next = rx_s;
            end
            if (cnt_reg == M_MID) begin
                samp_mid_next = rx_s;
            end
        end

        case (state_reg)
            S_IDLE: begin
                cnt_next      = '0;
                bit_idx_next  = '0;
                stop_idx_next = 1'b0;
                shift_next    = '0;
                xor_next      = 1'b0;
                zero_next     = 1'b1;
                perr_acc_next = 1'b0;
                ferr_acc_next = 1'b0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt_reg == M_HI && maj) begin
                    // Glitch, not a start bit.
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_reg == M_HI) begin
                    shift_next = {maj, shift_reg[DATA_BITS-1:1]};
                    xor_next   = xor_reg ^ maj;
                    zero_next  = zero_reg & ~maj;
                end else if (cnt_reg == CNT_MAX) begin
                    if (bit_idx_reg == LAST_IDX) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_reg == M_HI) begin
                    // par_calc is 1 when the total count of ones is odd.
                    perr_acc_next = (PARITY == 1) ? ~par_calc : par_calc;
                    zero_next     = zero_reg & ~maj;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_reg == M_HI) begin
                    ferr_acc_next = ferr_now;
                    if (last_stop) begin
                        cnt_next = '0;
                        if (zero_reg && !maj) begin
                            brk_next   = 1'b1;
                            state_next = S_WAIT_IDLE;
                        end else begin
                            byte_next  = shift_reg;
                            perr_next  = perr_acc_reg;
                            ferr_next  = ferr_now;
                            dv_next    = 1'b1;
                            state_next = maj ? S_IDLE : S_WAIT_IDLE;
                        end
                    end
                end else if (cnt_reg == CNT_MAX) begin
                    stop_idx_next = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                // A line still low after a bad stop bit must not look like a start bit.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            samp_lo_reg  <= 1'b0;
            samp_mid_reg <= 1'b0;
            shift_reg    <= '0;
            xor_reg      <= 1'b0;
            zero_reg     <= 1'b0;
            perr_acc_reg <= 1'b0;
            ferr_acc_reg <= 1'b0;
            byte_reg     <= '0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            dv_reg       <= 1'b0;
            brk_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            samp_lo_reg  <= samp_lo_next;
            samp_mid_reg <= samp_mid_next;
            shift_reg    <= shift_next;
            xor_reg      <= xor_next;
            zero_reg     <= zero_next;
            perr_acc_reg <= perr_acc_next;
            ferr_acc_reg <= ferr_acc_next;
            byte_reg     <= byte_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            dv_reg       <= dv_next;
            brk_reg      <= brk_next;
        end
    end

    assign rx_if.o_Rx_DV      = dv_reg;
    assign rx_if.o_Rx_Byte    = byte_reg;
    assign rx_if.o_Parity_Err = perr_reg;
    assign rx_if.o_Frame_Err  = ferr_reg;
    assign rx_if.o_Break      = brk_reg;
    assign rx_if.o_Busy       = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench: an 8N1 receiver and a 7E1 receiver, both at 16 clocks per bit.
module tb_uart_rx_frame;
    localparam int CPB       = 16;
    localparam int SPIKE_OFS = (CPB - 1) / 2 + 1;  // raw-pin offset that reaches the voter at count M
    localparam int LAT       = 156;                // pin edge to pulse: 2 sync cycles + t0+154

    logic clk = 1'b0;
    logic srst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_if #(.DATA_BITS(8)) ifa ();
    uart_rx_frame_if #(.DATA_BITS(7)) ifb ();

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_Clock (clk),
        .i_Reset (srst),
        .rx_if   (ifa)
    );

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .i_Clock (clk),
        .i_Reset (srst),
        .rx_if   (ifb)
    );

    int dv_a = 0, dv_cyc_a = 0, brk_a = 0, brk_cyc_a = 0;
    int dv_b = 0, dv_cyc_b = 0, brk_b = 0;

    // Pulse monitor, sampled on the falling edge; one line per received frame.
    always @(negedge clk) begin
        if (ifa.o_Rx_DV) begin
            dv_a     <= dv_a + 1;
            dv_cyc_a <= cyc;
            $display("rx A cycle %0d: byte=0x%02h perr=%0b ferr=%0b", cyc, ifa.o_Rx_Byte, ifa.o_Parity_Err, ifa.o_Frame_Err);
        end
        if (ifa.o_Break) begin
            brk_a     <= brk_a + 1;
            brk_cyc_a <= cyc;
            $display("rx A cycle %0d: break", cyc);
        end
        if (ifb.o_Rx_DV) begin
            dv_b     <= dv_b + 1;
            dv_cyc_b <= cyc;
            $display("rx B cycle %0d: byte=0x%02h perr=%0b ferr=%0b", cyc, ifb.o_Rx_Byte, ifb.o_Parity_Err, ifb.o_Frame_Err);
        end
        if (ifb.o_Break) begin
            brk_b <= brk_b + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold the selected pin at v for n clock cycles; returns #1 after a rising edge.
    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) ifa.i_Rx_Serial = v;
        else          ifb.i_Rx_Serial = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: start, nbits data LSB first, optional parity (par<0 = none),
    // stop level for stop_cyc cycles; spike = data bit index given a one-cycle high glitch.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int par, input logic stop_val, input int stop_cyc,
                              input int spike, output int k);
        logic [31:0] pv;
        k = cyc;
        drive(sel, 1'b0, CPB);
        for (int i = 0; i < nbits; i++) begin
            if (spike == i && !data[i]) begin
                drive(sel, 1'b0, SPIKE_OFS);
                drive(sel, 1'b1, 1);
                drive(sel, 1'b0, CPB - SPIKE_OFS - 1);
            end else begin
                drive(sel, data[i], CPB);
            end
        end
        if (par >= 0) begin
            pv = par;
            drive(sel, pv[0], CPB);
        end
        drive(sel, stop_val, stop_cyc);
    endtask

    initial begin
        int k;
        srst = 1'b1;
        ifa.i_Rx_Serial = 1'b1;
        ifb.i_Rx_Serial = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        srst = 1'b0;
        check("rst_dv",   ifa.o_Rx_DV, 0);
        check("rst_byte", ifa.o_Rx_Byte, 0);
        check("rst_busy", ifa.o_Busy, 0);
        check("rst_ferr", ifa.o_Frame_Err, 0);
        check("rst_brk",  ifa.o_Break, 0);
        drive(0, 1'b1, 5);

        // 8N1 0xA5, good stop
        send_frame(0, 9'h0A5, 8, -1, 1'b1, CPB, -1, k);
        check("a5_count", dv_a, 1);
        check("a5_time",  dv_cyc_a, k + LAT);
        check("a5_byte",  ifa.o_Rx_Byte, 8'hA5);
        check("a5_perr",  ifa.o_Parity_Err, 0);
        check("a5_ferr",  ifa.o_Frame_Err, 0);
        check("a5_busy",  ifa.o_Busy, 0);

        // 5-cycle low glitch, then a valid 0x3C
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 40);
        check("false_start_dv",   dv_a, 1);
        check("false_start_busy", ifa.o_Busy, 0);
        send_frame(0, 9'h03C, 8, -1, 1'b1, CPB, -1, k);
        check("3c_count", dv_a, 2);
        check("3c_time",  dv_cyc_a, k + LAT);
        check("3c_byte",  ifa.o_Rx_Byte, 8'h3C);

        // 7E1 0x03: two ones, parity 1 -> odd total -> error; parity 0 -> fine
        send_frame(1, 9'h003, 7, 1, 1'b1, CPB, -1, k);
        check("e7_count1", dv_b, 1);
        check("e7_time1",  dv_cyc_b, k + LAT);
        check("e7_byte1",  ifb.o_Rx_Byte, 7'h03);
        check("e7_perr1",  ifb.o_Parity_Err, 1);
        check("e7_ferr1",  ifb.o_Frame_Err, 0);
        send_frame(1, 9'h003, 7, 0, 1'b1, CPB, -1, k);
        check("e7_count2", dv_b, 2);
        check("e7_perr2",  ifb.o_Parity_Err, 0);
        check("e7_brk",    brk_b, 0);

        // 0x41 with stop low for 3 bit-times: framing error, low line not a start
        send_frame(0, 9'h041, 8, -1, 1'b0, 3 * CPB, -1, k);
        check("41_count", dv_a, 3);
        check("41_time",  dv_cyc_a, k + LAT);
        check("41_byte",  ifa.o_Rx_Byte, 8'h41);
        check("41_ferr",  ifa.o_Frame_Err, 1);
        check("41_busy_low", ifa.o_Busy, 1);
        drive(0, 1'b1, 8);
        check("41_busy_idle", ifa.o_Busy, 0);
        check("41_no_extra",  dv_a, 3);
        send_frame(0, 9'h042, 8, -1, 1'b1, CPB, -1, k);
        check("42_count", dv_a, 4);
        check("42_byte",  ifa.o_Rx_Byte, 8'h42);
        check("42_ferr",  ifa.o_Frame_Err, 0);

        // Line low for 20 bit-times: one break, nothing else
        k = cyc;
        drive(0, 1'b0, 20 * CPB);
        check("brk_count", brk_a, 1);
        check("brk_time",  brk_cyc_a, k + LAT);
        check("brk_no_dv", dv_a, 4);
        check("brk_byte",  ifa.o_Rx_Byte, 8'h42);
        check("brk_ferr",  ifa.o_Frame_Err, 0);
        check("brk_busy",  ifa.o_Busy, 1);
        drive(0, 1'b1, 8);
        check("brk_busy_idle", ifa.o_Busy, 0);

        // One-cycle spike at count M in data bit 0 of 0x10
        send_frame(0, 9'h010, 8, -1, 1'b1, CPB, 0, k);
        check("spike_count", dv_a, 5);
        check("spike_byte",  ifa.o_Rx_Byte, 8'h10);

        // Reset in the middle of a frame
        drive(0, 1'b0, 40);
        check("mid_busy", ifa.o_Busy, 1);
        srst = 1'b1;
        ifa.i_Rx_Serial = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        check("mrst_byte_a", ifa.o_Rx_Byte, 0);
        check("mrst_busy_a", ifa.o_Busy, 0);
        check("mrst_dv_a",   ifa.o_Rx_DV, 0);
        check("mrst_brk_a",  ifa.o_Break, 0);
        check("mrst_byte_b", ifb.o_Rx_Byte, 0);
        check("mrst_perr_b", ifb.o_Parity_Err, 0);
        drive(0, 1'b1, 200);
        check("mrst_no_dv",  dv_a, 5);
        check("mrst_no_brk", brk_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
